lc3b_dcache: RTL and testbench



---
 rtl/lc3b_dcache.sv | 122 ++++++++++++
 tb/tb_lc3b_dcache.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_dcache.sv
// rtl/lc3b_dcache.sv - direct-mapped write-back write-allocate data cache with 16-byte lines
module lc3b_dcache #(
    parameter int IDX_BITS  = 3,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [15:0]          mem_address,
    input  logic [15:0]          mem_wdata,
    input  logic [1:0]           mem_byte_enable,
    output logic [15:0]          mem_rdata,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [15:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int SETS     = 1 << IDX_BITS;
    localparam int TAG_BITS = 12 - IDX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    logic [1:0]           state;
    logic [SETS-1:0]      valid;
    logic [SETS-1:0]      dirty;
    logic [TAG_BITS-1:0]  tags  [SETS];
    logic [LINE_BITS-1:0] lines [SETS];

    logic [IDX_BITS-1:0]  idx;
    logic [IDX_BITS-1:0]  miss_idx;
    logic [TAG_BITS-1:0]  tag;
    logic [TAG_BITS-1:0]  miss_tag;
    logic [6:0]           lo_off;
    logic [6:0]           hi_off;
    logic                 req;
    logic                 hit;
    logic                 wr_hit;
    logic                 fill_done;
    logic                 unused_addr_bit;

    assign idx             = mem_address[3+IDX_BITS:4];
    assign tag             = mem_address[15:4+IDX_BITS];
    assign lo_off          = {mem_address[3:1], 4'b0000};
    assign hi_off          = {mem_address[3:1], 4'b1000};
    assign unused_addr_bit = mem_address[0];

    assign req       = mem_read | mem_write;
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign mem_resp  = (state == S_IDLE) && req && hit;
    // A simultaneous read+write is served as a read and never touches the array
    assign wr_hit    = mem_resp && mem_write && !mem_read;
    assign mem_rdata = lines[idx][lo_off +: 16];
    assign fill_done = (state == S_ALLOCATE) && pmem_resp;

    assign pmem_read  = (state == S_ALLOCATE);
    assign pmem_write = (state == S_WRITEBACK);
    assign pmem_wdata = lines[miss_idx];

    // The miss address is latched so the memory transfer stays stable even if the CPU drops its request
    always_comb begin
        pmem_address = {miss_tag, miss_idx, 4'b0000};
        if (state == S_WRITEBACK)
            pmem_address = {tags[miss_idx], miss_idx, 4'b0000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            valid    <= '0;
            dirty    <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && !hit) begin
                        miss_idx <= idx;
                        miss_tag <= tag;
                        state    <= dirty[idx] ? S_WRITEBACK : S_ALLOCATE;
                    end else if (wr_hit) begin
                        dirty[idx] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty[miss_idx] <= 1'b0;
                        state           <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line data and tags carry no reset; valid bits alone decide whether they mean anything
    always_ff @(posedge clk) begin
        if (fill_done) begin
            lines[miss_idx] <= pmem_rdata;
            tags[miss_idx]  <= miss_tag;
        end else if (wr_hit) begin
            if (mem_byte_enable[0])
                lines[idx][lo_off +: 8] <= mem_wdata[7:0];
            if (mem_byte_enable[1])
                lines[idx][hi_off +: 8] <= mem_wdata[15:8];
        end
    end

endmodule

// File: tb/tb_lc3b_dcache.sv
// tb/tb_lc3b_dcache.sv - self-checking bench for lc3b_dcache against a byte-level memory model
module tb_lc3b_dcache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address, mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    lc3b_dcache #(.IDX_BITS(3), .LINE_BITS(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } ev_t;

    logic [7:0]   ref_mem [65536];
    logic [127:0] phys    [4096];
    ev_t          ev_q    [$];

    int tests_run = 0, tests_failed = 0;
    int req_cnt = 0, resp_cnt = 0, both_cnt = 0, bad_resp = 0, unstable = 0;
    int fixed_delay = 0, spurious = 0;
    bit hold = 0;

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        return {ref_mem[{a[15:1], 1'b1}], ref_mem[{a[15:1], 1'b0}]};
    endfunction

    function automatic logic [127:0] ref_line(input logic [11:0] ln);
        logic [127:0] l;
        for (int b = 0; b < 16; b++) l[b*8 +: 8] = ref_mem[{ln, 4'(b)}];
        return l;
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
        if (be[0]) ref_mem[{a[15:1], 1'b0}] = wd[7:0];
        if (be[1]) ref_mem[{a[15:1], 1'b1}] = wd[15:8];
    endtask

    task automatic sync_ref();
        for (int i = 0; i < 4096; i++)
            for (int b = 0; b < 16; b++) ref_mem[{12'(i), 4'(b)}] = phys[i][b*8 +: 8];
    endtask

    // Physical memory responder with configurable latency
    initial begin : responder
        bit           busy = 0;
        int           remain = 0;
        logic [15:0]  cur_addr = '0;
        logic         cur_wr = 1'b0;
        logic [127:0] cur_wdata = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1; cur_addr = pmem_address; cur_wr = pmem_write; cur_wdata = pmem_wdata;
                    remain = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 10));
                end else if (pmem_address !== cur_addr || pmem_write !== cur_wr ||
                             (cur_wr && pmem_wdata !== cur_wdata)) begin
                    unstable++;
                end
                if (!hold) begin
                    if (remain == 0) begin
                        pmem_resp = 1'b1;
                        busy = 0;
                        if (cur_wr) phys[cur_addr[15:4]] = cur_wdata;
                        else pmem_rdata = phys[cur_addr[15:4]];
                        ev_q.push_back({cur_wr, cur_addr, cur_wr ? cur_wdata : phys[cur_addr[15:4]]});
                    end else begin
                        remain--;
                    end
                end
            end else begin
                busy = 0;
                if (spurious > 0) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    spurious--;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_resp) resp_cnt++;
            if (pmem_read && pmem_write) both_cnt++;
            if (mem_resp && (pmem_read || pmem_write)) bad_resp++;
        end
    end

    task automatic cpu_access(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wd, input logic [1:0] be,
                              output logic [15:0] rdata, output int cycles);
        bit done = 0;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        rdata = 'x; cycles = 0;
        req_cnt++;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            cycles++;
            if (mem_resp) begin rdata = mem_rdata; done = 1; end
        end
        if (!done) begin
            tests_run++; tests_failed++;
            $display("FAIL resp_timeout addr=%h: no mem_resp within 400 cycles", addr);
            cycles = -1;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    logic [15:0] rd;
    int          cyc, n0, r0;
    ev_t         e0, e1;

    task automatic get_evs(input int base);
        e0 = (ev_q.size() > base)     ? ev_q[base]     : ev_t'('0);
        e1 = (ev_q.size() > base + 1) ? ev_q[base + 1] : ev_t'('0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (mem_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_resp got %b want 0", mem_resp); end
        tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
        tests_run++; if (pmem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read();
        fixed_delay = 2; n0 = ev_q.size();
        cpu_access(1, 0, 16'h1234, '0, 2'b00, rd, cyc);
        get_evs(n0);
        tests_run++; if (rd !== 16'hBEEF) begin tests_failed++; $display("FAIL cold_data got %h want BEEF", rd); end
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL cold_latency got %0d want 5", cyc); end
        tests_run++; if (ev_q.size() != n0 + 1 || e0.wr !== 1'b0 || e0.addr !== 16'h1230) begin
            tests_failed++; $display("FAIL cold_fill got n=%0d wr=%b addr=%h want 1 read at 1230", ev_q.size() - n0, e0.wr, e0.addr); end
        n0 = ev_q.size();
        cpu_access(1, 0, 16'h1234, '0, 2'b00, rd, cyc);
        tests_run++; if (rd !== 16'hBEEF || cyc != 1 || ev_q.size() != n0) begin
            tests_failed++; $display("FAIL repeat_hit got data=%h cyc=%0d pmem=%0d want BEEF 1 0", rd, cyc, ev_q.size() - n0); end
    endtask

    task automatic test_write_hit();
        n0 = ev_q.size();
        cpu_access(0, 1, 16'h1234, 16'hA55A, 2'b01, rd, cyc);
        ref_write(16'h1234, 16'hA55A, 2'b01);
        tests_run++; if (cyc != 1 || ev_q.size() != n0) begin
            tests_failed++; $display("FAIL write_hit got cyc=%0d pmem=%0d want 1 0", cyc, ev_q.size() - n0); end
        cpu_access(1, 0, 16'h1234, '0, 2'b00, rd, cyc);
        tests_run++; if (rd !== 16'hBE5A) begin tests_failed++; $display("FAIL write_merge got %h want BE5A", rd); end
    endtask

    task automatic test_dirty_conflict();
        fixed_delay = 1; n0 = ev_q.size(); r0 = resp_cnt;
        cpu_access(1, 0, 16'h12B4, '0, 2'b00, rd, cyc);
        get_evs(n0);
        tests_run++; if (ev_q.size() != n0 + 2 || e0.wr !== 1'b1 || e0.addr !== 16'h1230 || e0.data[47:32] !== 16'hBE5A) begin
            tests_failed++; $display("FAIL wb_event got n=%0d wr=%b addr=%h word=%h want write 1230 BE5A", ev_q.size() - n0, e0.wr, e0.addr, e0.data[47:32]); end
        tests_run++; if (e0.data !== ref_line(12'h123)) begin
            tests_failed++; $display("FAIL wb_line got %h want %h", e0.data, ref_line(12'h123)); end
        tests_run++; if (e1.wr !== 1'b0 || e1.addr !== 16'h12B0) begin
            tests_failed++; $display("FAIL wb_then_fill got wr=%b addr=%h want read 12B0", e1.wr, e1.addr); end
        tests_run++; if (rd !== ref_word(16'h12B4) || cyc != 6) begin
            tests_failed++; $display("FAIL conflict_read got %h cyc=%0d want %h cyc=6", rd, cyc, ref_word(16'h12B4)); end
        tests_run++; if (resp_cnt - r0 != 1) begin tests_failed++; $display("FAIL one_resp got %0d want 1", resp_cnt - r0); end
    endtask

    task automatic test_clean_eviction();
        int wr_seen = 0;
        n0 = ev_q.size();
        cpu_access(1, 0, 16'h1230, '0, 2'b00, rd, cyc);
        tests_run++; if (rd !== ref_word(16'h1230)) begin tests_failed++; $display("FAIL clean_a got %h want %h", rd, ref_word(16'h1230)); end
        cpu_access(1, 0, 16'h12B0, '0, 2'b00, rd, cyc);
        tests_run++; if (rd !== ref_word(16'h12B0)) begin tests_failed++; $display("FAIL clean_b got %h want %h", rd, ref_word(16'h12B0)); end
        for (int i = n0; i < ev_q.size(); i++) if (ev_q[i].wr) wr_seen++;
        tests_run++; if (ev_q.size() != n0 + 2 || wr_seen != 0) begin
            tests_failed++; $display("FAIL clean_evict got events=%0d writes=%0d want 2 0", ev_q.size() - n0, wr_seen); end
    endtask

    task automatic test_byte_enable_zero();
        cpu_access(0, 1, 16'h12B2, 16'hFFFF, 2'b00, rd, cyc);
        tests_run++; if (cyc != 1) begin tests_failed++; $display("FAIL be0_resp got cyc=%0d want 1", cyc); end
        cpu_access(1, 0, 16'h12B2, '0, 2'b00, rd, cyc);
        tests_run++; if (rd !== ref_word(16'h12B2)) begin tests_failed++; $display("FAIL be0_data got %h want %h", rd, ref_word(16'h12B2)); end
        n0 = ev_q.size();
        cpu_access(1, 0, 16'h1234, '0, 2'b00, rd, cyc);
        get_evs(n0);
        tests_run++; if (e0.wr !== 1'b1 || e0.addr !== 16'h12B0) begin
            tests_failed++; $display("FAIL be0_dirty got wr=%b addr=%h want write 12B0", e0.wr, e0.addr); end
        tests_run++; if (rd !== ref_word(16'h1234)) begin tests_failed++; $display("FAIL be0_refill got %h want %h", rd, ref_word(16'h1234)); end
    endtask

    task automatic test_read_write_both();
        cpu_access(1, 1, 16'h1236, 16'h1111, 2'b11, rd, cyc);
        tests_run++; if (rd !== ref_word(16'h1236) || cyc != 1) begin
            tests_failed++; $display("FAIL rw_both got %h cyc=%0d want %h cyc=1", rd, cyc, ref_word(16'h1236)); end
        n0 = ev_q.size();
        cpu_access(1, 0, 16'h12B6, '0, 2'b00, rd, cyc);
        get_evs(n0);
        tests_run++; if (ev_q.size() != n0 + 1 || e0.wr !== 1'b0) begin
            tests_failed++; $display("FAIL rw_both_clean got events=%0d wr=%b want 1 read", ev_q.size() - n0, e0.wr); end
    endtask

    task automatic test_idle_resp();
        spurious = 3;
        repeat (6) @(posedge clk);
        #1; n0 = ev_q.size();
        cpu_access(1, 0, 16'h12B6, '0, 2'b00, rd, cyc);
        tests_run++; if (rd !== ref_word(16'h12B6) || cyc != 1 || ev_q.size() != n0) begin
            tests_failed++; $display("FAIL idle_resp got %h cyc=%0d pmem=%0d want %h 1 0", rd, cyc, ev_q.size() - n0, ref_word(16'h12B6)); end
    endtask

    task automatic test_reset_mid_allocate();
        bit seen = 0;
        cpu_access(1, 0, 16'h4560, '0, 2'b00, rd, cyc);
        hold = 1;
        mem_read = 1'b1; mem_address = 16'h1230;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (pmem_read) seen = 1;
        end
        tests_run++; if (!seen || pmem_address !== 16'h1230) begin
            tests_failed++; $display("FAIL mid_alloc_req got seen=%b addr=%h want 1 1230", seen, pmem_address); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            tests_failed++; $display("FAIL async_drop got rd=%b wr=%b want 0 0", pmem_read, pmem_write); end
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1; hold = 0;
        @(posedge clk); #1;
        sync_ref();
        n0 = ev_q.size();
        cpu_access(1, 0, 16'h1230, '0, 2'b00, rd, cyc);
        get_evs(n0);
        tests_run++; if (ev_q.size() != n0 + 1 || e0.addr !== 16'h1230 || rd !== ref_word(16'h1230)) begin
            tests_failed++; $display("FAIL post_reset_miss got events=%0d addr=%h data=%h want 1 1230 %h", ev_q.size() - n0, e0.addr, rd, ref_word(16'h1230)); end
        n0 = ev_q.size();
        cpu_access(1, 0, 16'h4560, '0, 2'b00, rd, cyc);
        tests_run++; if (ev_q.size() != n0 + 1) begin
            tests_failed++; $display("FAIL post_reset_invalid got events=%0d want 1", ev_q.size() - n0); end
    endtask

    task automatic test_random();
        logic [8:0]  tag_pool [4] = '{9'h01A, 9'h0F3, 9'h155, 9'h1FF};
        logic [15:0] a, wd, exp;
        logic [1:0]  be;
        fixed_delay = -1;
        for (int i = 0; i < 400; i++) begin
            a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0};
            if ($urandom_range(0, 1) == 0) begin
                exp = ref_word(a);
                cpu_access(1, 0, a, '0, 2'b00, rd, cyc);
                tests_run++; if (rd !== exp) begin tests_failed++; $display("FAIL rand_read addr=%h got %h want %h", a, rd, exp); end
            end else begin
                wd = 16'($urandom); be = 2'($urandom_range(0, 3));
                cpu_access(0, 1, a, wd, be, rd, cyc);
                ref_write(a, wd, be);
            end
        end
        tests_run++; if (resp_cnt != req_cnt) begin tests_failed++; $display("FAIL resp_count got %0d want %0d", resp_cnt, req_cnt); end
        tests_run++; if (both_cnt != 0) begin tests_failed++; $display("FAIL pmem_both got %0d want 0", both_cnt); end
        tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL pmem_stable got %0d want 0", unstable); end
        tests_run++; if (bad_resp != 0) begin tests_failed++; $display("FAIL resp_outside_idle got %0d want 0", bad_resp); end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) phys[i] = {$urandom, $urandom, $urandom, $urandom};
        phys[12'h123][47:32] = 16'hBEEF;
        sync_ref();
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_conflict();
        test_clean_eviction();
        test_byte_enable_zero();
        test_read_write_both();
        test_idle_resp();
        test_reset_mid_allocate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
